input_port_credit: RTL and testbench

- Parameterised successor of the router input port.
- Holds VC_NUM per-VC FIFOs of configurable depth and flit width.
- Runs a per-VC packet FSM (IDLE/VA/ACTIVE) with head-flit XY route computation and downstream-VC rewrite.
- Returns credits upstream instead of on/off signalling. Sits between the upstream link and the VC/switch allocators plus crossbar.

---
 rtl/input_port_credit.sv | 233 +++++++++++++++++++++++
 tb/tb_input_port_credit.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/input_port_credit.sv
// Router input port with per-VC FIFOs, per-VC packet FSM (IDLE/VA/ACTIVE),
// XY route computation, downstream-VC rewrite and credit-based flow control.
module input_port_credit #(
  parameter int VC_NUM      = 4,
  parameter int BUFFER_SIZE = 8,
  parameter int FLIT_W      = 32,
  parameter int X_CURRENT   = 2,
  parameter int Y_CURRENT   = 2,
  parameter int COORD_W     = 3
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [FLIT_W-1:0]                data_i,
  input  logic                             valid_i,
  input  logic [VC_NUM-1:0]                va_grant_i,
  input  logic [VC_NUM*$clog2(VC_NUM)-1:0] va_vc_i,
  input  logic                             sa_grant_i,
  input  logic [$clog2(VC_NUM)-1:0]        sa_vc_i,
  output logic [FLIT_W-1:0]                flit_o,
  output logic                             flit_valid_o,
  output logic                             credit_valid_o,
  output logic [$clog2(VC_NUM)-1:0]        credit_vc_o,
  output logic [VC_NUM-1:0]                vc_request_o,
  output logic [VC_NUM-1:0]                switch_request_o,
  output logic [VC_NUM*3-1:0]              out_port_o,
  output logic [VC_NUM*$clog2(VC_NUM)-1:0] downstream_vc_o,
  output logic [VC_NUM-1:0]                is_empty_o,
  output logic [VC_NUM-1:0]                is_full_o,
  output logic                             err_o
);

  localparam int VC_W  = $clog2(VC_NUM);
  localparam int IDX_W = $clog2(BUFFER_SIZE);
  localparam int PTR_W = IDX_W + 1;

  localparam logic [1:0] T_HEAD     = 2'b00;
  localparam logic [1:0] T_BODY     = 2'b01;
  localparam logic [1:0] T_TAIL     = 2'b10;
  localparam logic [1:0] T_HEADTAIL = 2'b11;

  localparam logic [2:0] P_LOCAL = 3'd0;
  localparam logic [2:0] P_NORTH = 3'd1;
  localparam logic [2:0] P_SOUTH = 3'd2;
  localparam logic [2:0] P_WEST  = 3'd3;
  localparam logic [2:0] P_EAST  = 3'd4;

  typedef enum logic [1:0] {S_IDLE, S_VA, S_ACTIVE} state_t;

  state_t            state_q  [VC_NUM];
  state_t            state_d  [VC_NUM];
  logic [PTR_W-1:0]  wr_ptr_q [VC_NUM];
  logic [PTR_W-1:0]  wr_ptr_d [VC_NUM];
  logic [PTR_W-1:0]  rd_ptr_q [VC_NUM];
  logic [PTR_W-1:0]  rd_ptr_d [VC_NUM];
  logic [2:0]        route_q  [VC_NUM];
  logic [2:0]        route_d  [VC_NUM];
  logic [VC_W-1:0]   dvc_q    [VC_NUM];
  logic [VC_W-1:0]   dvc_d    [VC_NUM];
  logic [FLIT_W-1:0] mem_q    [VC_NUM][BUFFER_SIZE];
  logic [FLIT_W-1:0] front    [VC_NUM];

  logic [VC_NUM-1:0] empty_q, empty_d, full_q, full_d;
  logic [VC_NUM-1:0] discard_req, sw_req, push, pop;
  logic              err_q, err_d;
  logic [VC_W-1:0]   wr_vc, pop_vc;
  logic              pop_en, sa_pop;

  // Two-stage output: pop stage captures the flit, output stage presents it.
  logic              s1_fv_q, s1_fv_d, s1_cv_q, s1_cv_d;
  logic [VC_W-1:0]   s1_vc_q, s1_vc_d;
  logic [FLIT_W-1:0] s1_flit_q, s1_flit_d;
  logic              fv_q, cv_q;
  logic [VC_W-1:0]   cvc_q;
  logic [FLIT_W-1:0] flit_q;

  function automatic logic [2:0] xy_route(input logic [COORD_W-1:0] xd,
                                          input logic [COORD_W-1:0] yd);
    logic [2:0] r;
    if (xd > COORD_W'(X_CURRENT))      r = P_EAST;
    else if (xd < COORD_W'(X_CURRENT)) r = P_WEST;
    else if (yd > COORD_W'(Y_CURRENT)) r = P_SOUTH;
    else if (yd < COORD_W'(Y_CURRENT)) r = P_NORTH;
    else                               r = P_LOCAL;
    return r;
  endfunction

  assign wr_vc = data_i[FLIT_W-3 -: VC_W];

  always_comb begin
    discard_req      = '0;
    sw_req           = '0;
    vc_request_o     = '0;
    out_port_o       = '0;
    downstream_vc_o  = '0;
    for (int unsigned v = 0; v < VC_NUM; v++) begin
      front[v]       = mem_q[v][rd_ptr_q[v][IDX_W-1:0]];
      discard_req[v] = (state_q[v] == S_IDLE) && !empty_q[v] &&
                       ((front[v][FLIT_W-1 -: 2] == T_BODY) ||
                        (front[v][FLIT_W-1 -: 2] == T_TAIL));
      sw_req[v]      = (state_q[v] == S_ACTIVE) && !empty_q[v];
      vc_request_o[v] = (state_q[v] == S_VA);
      out_port_o[v*3 +: 3]           = route_q[v];
      downstream_vc_o[v*VC_W +: VC_W] = dvc_q[v];
    end
  end

  assign switch_request_o = sw_req;

  // SA pops take priority; otherwise the lowest-index stray BODY/TAIL is discarded.
  always_comb begin
    sa_pop = sa_grant_i && sw_req[sa_vc_i];
    pop_en = sa_pop;
    pop_vc = sa_vc_i;
    if (!sa_pop) begin
      for (int unsigned i = VC_NUM; i > 0; i--) begin
        if (discard_req[i-1]) begin
          pop_en = 1'b1;
          pop_vc = VC_W'(i-1);
        end
      end
    end
    pop = '0;
    if (pop_en) pop[pop_vc] = 1'b1;
  end

  always_comb begin
    for (int unsigned v = 0; v < VC_NUM; v++) begin
      push[v]     = valid_i && (wr_vc == VC_W'(v)) && (!full_q[v] || pop[v]);
      wr_ptr_d[v] = wr_ptr_q[v] + PTR_W'(push[v]);
      rd_ptr_d[v] = rd_ptr_q[v] + PTR_W'(pop[v]);
      empty_d[v]  = (wr_ptr_d[v] == rd_ptr_d[v]);
      full_d[v]   = (wr_ptr_d[v][IDX_W-1:0] == rd_ptr_d[v][IDX_W-1:0]) &&
                    (wr_ptr_d[v][IDX_W] != rd_ptr_d[v][IDX_W]);
    end
    err_d = err_q | (valid_i & full_q[wr_vc] & ~pop[wr_vc]) | (pop_en & ~sa_pop);
  end

  always_comb begin
    for (int unsigned v = 0; v < VC_NUM; v++) begin
      state_d[v] = state_q[v];
      route_d[v] = route_q[v];
      dvc_d[v]   = dvc_q[v];
      case (state_q[v])
        S_IDLE: begin
          if (!empty_q[v] && ((front[v][FLIT_W-1 -: 2] == T_HEAD) ||
                              (front[v][FLIT_W-1 -: 2] == T_HEADTAIL))) begin
            route_d[v] = xy_route(front[v][2*COORD_W-1:COORD_W], front[v][COORD_W-1:0]);
            state_d[v] = S_VA;
          end
        end
        S_VA: begin
          if (va_grant_i[v]) begin
            dvc_d[v]   = va_vc_i[v*VC_W +: VC_W];
            state_d[v] = S_ACTIVE;
          end
        end
        S_ACTIVE: begin
          // TAIL (10) and HEADTAIL (11) share the set MSB
          if (pop[v] && front[v][FLIT_W-1]) state_d[v] = S_IDLE;
        end
        default: state_d[v] = S_IDLE;
      endcase
    end
  end

  always_comb begin
    s1_fv_d   = sa_pop;
    s1_cv_d   = pop_en;
    s1_vc_d   = pop_vc;
    s1_flit_d = '0;
    if (sa_pop) begin
      s1_flit_d = front[pop_vc];
      s1_flit_d[FLIT_W-3 -: VC_W] = dvc_q[pop_vc];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned v = 0; v < VC_NUM; v++) begin
        state_q[v]  <= S_IDLE;
        wr_ptr_q[v] <= '0;
        rd_ptr_q[v] <= '0;
        route_q[v]  <= '0;
        dvc_q[v]    <= '0;
      end
      empty_q   <= '1;
      full_q    <= '0;
      err_q     <= 1'b0;
      s1_fv_q   <= 1'b0;
      s1_cv_q   <= 1'b0;
      s1_vc_q   <= '0;
      s1_flit_q <= '0;
      fv_q      <= 1'b0;
      cv_q      <= 1'b0;
      cvc_q     <= '0;
      flit_q    <= '0;
    end else begin
      for (int unsigned v = 0; v < VC_NUM; v++) begin
        state_q[v]  <= state_d[v];
        wr_ptr_q[v] <= wr_ptr_d[v];
        rd_ptr_q[v] <= rd_ptr_d[v];
        route_q[v]  <= route_d[v];
        dvc_q[v]    <= dvc_d[v];
      end
      empty_q   <= empty_d;
      full_q    <= full_d;
      err_q     <= err_d;
      s1_fv_q   <= s1_fv_d;
      s1_cv_q   <= s1_cv_d;
      s1_vc_q   <= s1_vc_d;
      s1_flit_q <= s1_flit_d;
      fv_q      <= s1_fv_q;
      cv_q      <= s1_cv_q;
      cvc_q     <= s1_vc_q;
      flit_q    <= s1_flit_q;
    end
  end

  always_ff @(posedge clk) begin
    for (int unsigned v = 0; v < VC_NUM; v++) begin
      if (push[v]) mem_q[v][wr_ptr_q[v][IDX_W-1:0]] <= data_i;
    end
  end

  assign flit_o         = flit_q;
  assign flit_valid_o   = fv_q;
  assign credit_valid_o = cv_q;
  assign credit_vc_o    = cvc_q;
  assign is_empty_o     = empty_q;
  assign is_full_o      = full_q;
  assign err_o          = err_q;

endmodule

// File: tb/tb_input_port_credit.sv
// Directed bench for input_port_credit: a per-cycle vector table plus
// hand-written sequences for overflow, interleaving and mid-packet reset.
module tb_input_port_credit;

  logic        clk, rst;
  logic [31:0] data_i;
  logic        valid_i;
  logic [3:0]  va_grant_i;
  logic [7:0]  va_vc_i;
  logic        sa_grant_i;
  logic [1:0]  sa_vc_i;
  logic [31:0] flit_o;
  logic        flit_valid_o, credit_valid_o;
  logic [1:0]  credit_vc_o;
  logic [3:0]  vc_request_o, switch_request_o, is_empty_o, is_full_o;
  logic [11:0] out_port_o;
  logic [7:0]  downstream_vc_o;
  logic        err_o;

  input_port_credit #(
    .VC_NUM(4), .BUFFER_SIZE(8), .FLIT_W(32),
    .X_CURRENT(2), .Y_CURRENT(2), .COORD_W(3)
  ) dut (
    .clk(clk), .rst(rst), .data_i(data_i), .valid_i(valid_i),
    .va_grant_i(va_grant_i), .va_vc_i(va_vc_i),
    .sa_grant_i(sa_grant_i), .sa_vc_i(sa_vc_i),
    .flit_o(flit_o), .flit_valid_o(flit_valid_o),
    .credit_valid_o(credit_valid_o), .credit_vc_o(credit_vc_o),
    .vc_request_o(vc_request_o), .switch_request_o(switch_request_o),
    .out_port_o(out_port_o), .downstream_vc_o(downstream_vc_o),
    .is_empty_o(is_empty_o), .is_full_o(is_full_o), .err_o(err_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic [1:0] HD = 2'b00, BD = 2'b01, TL = 2'b10, HT = 2'b11;

  typedef struct packed {
    logic        rst;
    logic        valid;
    logic [31:0] data;
    logic [3:0]  vag;
    logic [7:0]  vav;
    logic        sag;
    logic [1:0]  sav;
    logic        fv;
    logic [31:0] flit;
    logic        cv;
    logic [1:0]  cvc;
    logic [3:0]  vreq;
    logic [3:0]  sreq;
    logic [3:0]  emp;
    logic [3:0]  full;
    logic        err;
    logic [11:0] port;
    logic [7:0]  dvc;
  } vec_t;

  vec_t        tbl[$];
  logic [31:0] got_f[$];
  logic [1:0]  got_c[$];
  logic [31:0] exp_f[$];
  int          checks = 0;
  int          errors = 0;

  function automatic logic [31:0] mk(logic [1:0] t, logic [1:0] vc, logic [2:0] x,
                                     logic [2:0] y, logic [21:0] p);
    return {t, vc, p, x, y};
  endfunction

  function automatic logic [31:0] rw(logic [31:0] f, logic [1:0] d);
    logic [31:0] r;
    r = f;
    r[29:28] = d;
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", name, got, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [31:0] d, input logic [3:0] vag,
                       input logic [7:0] vav, input logic sag, input logic [1:0] sav);
    valid_i = v; data_i = d; va_grant_i = vag; va_vc_i = vav;
    sa_grant_i = sag; sa_vc_i = sav;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    if (flit_valid_o) got_f.push_back(flit_o);
    if (credit_valid_o) got_c.push_back(credit_vc_o);
  endtask

  task automatic add(input logic r, input logic v, input logic [31:0] d,
                     input logic [3:0] vag, input logic [7:0] vav, input logic sag,
                     input logic [1:0] sav, input logic fv, input logic [31:0] fl,
                     input logic cv, input logic [1:0] cvc, input logic [3:0] vreq,
                     input logic [3:0] sreq, input logic [3:0] emp, input logic [3:0] full,
                     input logic err, input logic [11:0] port, input logic [7:0] dvc);
    tbl.push_back({r, v, d, vag, vav, sag, sav, fv, fl, cv, cvc, vreq, sreq, emp, full,
                   err, port, dvc});
  endtask

  task automatic reset_dut();
    rst = 1'b1;
    drive(0, 0, 0, 0, 0, 0);
    step();
    rst = 1'b0;
    got_f.delete();
    got_c.delete();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] f1, h, b1, b2, t, bx, h0, h3, b0, b3, t0, t3;
    f1 = mk(HT, 2'd1, 3'd3, 3'd2, 22'd1);
    h  = mk(HD, 2'd0, 3'd2, 3'd0, 22'd2);
    b1 = mk(BD, 2'd0, 3'd0, 3'd0, 22'd3);
    b2 = mk(BD, 2'd0, 3'd0, 3'd0, 22'd4);
    t  = mk(TL, 2'd0, 3'd0, 3'd0, 22'd5);
    bx = mk(BD, 2'd1, 3'd0, 3'd0, 22'd7);

    // HEADTAIL on vc1 to EAST, downstream vc 3
    add(1,0,0,     0,0,0,0, 0,0,0,0, 4'h0,4'h0,4'hF,4'h0,0,12'h000,8'h00);
    add(0,1,f1,    0,0,0,0, 0,0,0,0, 4'h0,4'h0,4'hD,4'h0,0,12'h000,8'h00);
    add(0,0,0,     0,0,0,0, 0,0,0,0, 4'h2,4'h0,4'hD,4'h0,0,12'h020,8'h00);
    add(0,0,0, 4'h2,8'h0C,0,0, 0,0,0,0, 4'h0,4'h2,4'hD,4'h0,0,12'h020,8'h0C);
    add(0,0,0,     0,0,1,1, 0,0,0,0, 4'h0,4'h0,4'hF,4'h0,0,12'h020,8'h0C);
    add(0,0,0,     0,0,0,0, 1,rw(f1,2'd3),1,1, 4'h0,4'h0,4'hF,4'h0,0,12'h020,8'h0C);
    add(0,0,0,     0,0,0,0, 0,0,0,0, 4'h0,4'h0,4'hF,4'h0,0,12'h020,8'h0C);
    // 4-flit packet on vc0 to NORTH, downstream vc 2, SA granting every cycle
    add(0,1,h,     0,0,0,0, 0,0,0,0, 4'h0,4'h0,4'hE,4'h0,0,12'h020,8'h0C);
    add(0,1,b1,    0,0,0,0, 0,0,0,0, 4'h1,4'h0,4'hE,4'h0,0,12'h021,8'h0C);
    add(0,1,b2, 4'h1,8'h02,0,0, 0,0,0,0, 4'h0,4'h1,4'hE,4'h0,0,12'h021,8'h0E);
    add(0,1,t,     0,0,1,0, 0,0,0,0, 4'h0,4'h1,4'hE,4'h0,0,12'h021,8'h0E);
    add(0,0,0,     0,0,1,0, 1,rw(h,2'd2),1,0,  4'h0,4'h1,4'hE,4'h0,0,12'h021,8'h0E);
    add(0,0,0,     0,0,1,0, 1,rw(b1,2'd2),1,0, 4'h0,4'h1,4'hE,4'h0,0,12'h021,8'h0E);
    add(0,0,0,     0,0,1,0, 1,rw(b2,2'd2),1,0, 4'h0,4'h0,4'hF,4'h0,0,12'h021,8'h0E);
    add(0,0,0,     0,0,1,0, 1,rw(t,2'd2),1,0,  4'h0,4'h0,4'hF,4'h0,0,12'h021,8'h0E);
    add(0,0,0,     0,0,0,0, 0,0,0,0, 4'h0,4'h0,4'hF,4'h0,0,12'h021,8'h0E);
    // stray BODY on vc1: discarded with error and credit
    add(1,0,0,     0,0,0,0, 0,0,0,0, 4'h0,4'h0,4'hF,4'h0,0,12'h000,8'h00);
    add(0,1,bx,    0,0,0,0, 0,0,0,0, 4'h0,4'h0,4'hD,4'h0,0,12'h000,8'h00);
    add(0,0,0,     0,0,0,0, 0,0,0,0, 4'h0,4'h0,4'hF,4'h0,1,12'h000,8'h00);
    add(0,0,0,     0,0,0,0, 0,0,1,1, 4'h0,4'h0,4'hF,4'h0,1,12'h000,8'h00);
    add(0,0,0,     0,0,0,0, 0,0,0,0, 4'h0,4'h0,4'hF,4'h0,1,12'h000,8'h00);

    rst = 1'b1;
    drive(0, 0, 0, 0, 0, 0);
    foreach (tbl[i]) begin
      rst = tbl[i].rst;
      drive(tbl[i].valid, tbl[i].data, tbl[i].vag, tbl[i].vav, tbl[i].sag, tbl[i].sav);
      step();
      chk($sformatf("r%0d flit_valid", i), 32'(flit_valid_o), 32'(tbl[i].fv));
      if (tbl[i].fv) chk($sformatf("r%0d flit", i), flit_o, tbl[i].flit);
      chk($sformatf("r%0d credit_valid", i), 32'(credit_valid_o), 32'(tbl[i].cv));
      if (tbl[i].cv) chk($sformatf("r%0d credit_vc", i), 32'(credit_vc_o), 32'(tbl[i].cvc));
      chk($sformatf("r%0d vc_request", i), 32'(vc_request_o), 32'(tbl[i].vreq));
      chk($sformatf("r%0d switch_request", i), 32'(switch_request_o), 32'(tbl[i].sreq));
      chk($sformatf("r%0d is_empty", i), 32'(is_empty_o), 32'(tbl[i].emp));
      chk($sformatf("r%0d is_full", i), 32'(is_full_o), 32'(tbl[i].full));
      chk($sformatf("r%0d err", i), 32'(err_o), 32'(tbl[i].err));
      chk($sformatf("r%0d out_port", i), 32'(out_port_o), 32'(tbl[i].port));
      chk($sformatf("r%0d downstream_vc", i), 32'(downstream_vc_o), 32'(tbl[i].dvc));
    end

    // Fill vc2, push+pop while full, then overflow drops the 9th flit
    reset_dut();
    exp_f.delete();
    for (int i = 0; i < 8; i++) begin
      drive(1, mk(i == 0 ? HD : BD, 2'd2, 3'd0, 3'd0, 22'(i)), 0, 0, 0, 0);
      step();
      exp_f.push_back(rw(mk(i == 0 ? HD : BD, 2'd2, 3'd0, 3'd0, 22'(i)), 2'd1));
    end
    chk("fill is_full", 32'(is_full_o), 32'h4);
    chk("fill err", 32'(err_o), 32'h0);
    drive(0, 0, 4'h4, 8'h10, 0, 0);
    step();
    chk("fill sw_req", 32'(switch_request_o), 32'h4);
    drive(1, mk(TL, 2'd2, 3'd0, 3'd0, 22'd8), 0, 0, 1, 2'd2);
    exp_f.push_back(rw(mk(TL, 2'd2, 3'd0, 3'd0, 22'd8), 2'd1));
    step();
    chk("pushpop is_full", 32'(is_full_o), 32'h4);
    chk("pushpop err", 32'(err_o), 32'h0);
    drive(1, mk(BD, 2'd2, 3'd0, 3'd0, 22'd9), 0, 0, 0, 0);
    step();
    chk("overflow err", 32'(err_o), 32'h1);
    chk("overflow is_full", 32'(is_full_o), 32'h4);
    for (int i = 0; i < 12; i++) begin
      drive(0, 0, 0, 0, 1, 2'd2);
      step();
    end
    drive(0, 0, 0, 0, 0, 0);
    step();
    step();
    chk("drain count", 32'(got_f.size()), 32'd9);
    for (int i = 0; i < 9; i++) begin
      if (i < got_f.size()) chk($sformatf("drain flit%0d", i), got_f[i], exp_f[i]);
    end
    chk("drain credits", 32'(got_c.size()), 32'd9);
    chk("drain is_empty", 32'(is_empty_o), 32'hF);

    // Interleaved packets on vc0 (WEST, dvc1) and vc3 (SOUTH, dvc2)
    reset_dut();
    h0 = mk(HD, 2'd0, 3'd1, 3'd2, 22'd16);
    h3 = mk(HD, 2'd3, 3'd2, 3'd3, 22'd17);
    b0 = mk(BD, 2'd0, 3'd0, 3'd0, 22'd18);
    b3 = mk(BD, 2'd3, 3'd0, 3'd0, 22'd19);
    t0 = mk(TL, 2'd0, 3'd0, 3'd0, 22'd20);
    t3 = mk(TL, 2'd3, 3'd0, 3'd0, 22'd21);
    drive(1, h0, 0, 0, 0, 0);        step();
    drive(1, h3, 0, 0, 0, 0);        step();
    drive(1, b0, 0, 0, 0, 0);        step();
    drive(1, b3, 4'h9, 8'h81, 0, 0); step();
    drive(1, t0, 0, 0, 1, 2'd0);     step();
    drive(1, t3, 0, 0, 1, 2'd3);     step();
    for (int i = 0; i < 4; i++) begin
      drive(0, 0, 0, 0, 1, (i % 2 == 0) ? 2'd0 : 2'd3);
      step();
    end
    drive(0, 0, 0, 0, 0, 0);
    step();
    step();
    exp_f.delete();
    exp_f.push_back(rw(h0, 2'd1)); exp_f.push_back(rw(h3, 2'd2));
    exp_f.push_back(rw(b0, 2'd1)); exp_f.push_back(rw(b3, 2'd2));
    exp_f.push_back(rw(t0, 2'd1)); exp_f.push_back(rw(t3, 2'd2));
    chk("ilv count", 32'(got_f.size()), 32'd6);
    chk("ilv credit count", 32'(got_c.size()), 32'd6);
    for (int i = 0; i < 6; i++) begin
      if (i < got_f.size()) chk($sformatf("ilv flit%0d", i), got_f[i], exp_f[i]);
      if (i < got_c.size()) chk($sformatf("ilv credit%0d", i), 32'(got_c[i]),
                                (i % 2 == 0) ? 32'd0 : 32'd3);
    end
    chk("ilv port vc0", 32'(out_port_o[2:0]), 32'd3);
    chk("ilv port vc3", 32'(out_port_o[11:9]), 32'd2);
    chk("ilv downstream_vc", 32'(downstream_vc_o), 32'h81);
    chk("ilv is_empty", 32'(is_empty_o), 32'hF);

    // Asynchronous reset while vc0 is ACTIVE with a pop in flight
    reset_dut();
    drive(1, mk(HD, 2'd0, 3'd3, 3'd3, 22'd30), 0, 0, 0, 0); step();
    drive(1, mk(BD, 2'd0, 3'd0, 3'd0, 22'd31), 0, 0, 0, 0); step();
    drive(1, mk(BD, 2'd0, 3'd0, 3'd0, 22'd32), 4'h1, 8'h01, 0, 0); step();
    drive(0, 0, 0, 0, 1, 2'd0); step();
    chk("pre-rst sw_req", 32'(switch_request_o), 32'h1);
    drive(0, 0, 0, 0, 0, 0);
    #2;
    rst = 1'b1;
    #1;
    chk("arst flit_valid", 32'(flit_valid_o), 32'h0);
    chk("arst flit", flit_o, 32'h0);
    chk("arst credit_valid", 32'(credit_valid_o), 32'h0);
    chk("arst requests", {vc_request_o, switch_request_o}, 32'h0);
    chk("arst is_empty", 32'(is_empty_o), 32'hF);
    chk("arst is_full", 32'(is_full_o), 32'h0);
    chk("arst route/dvc", {out_port_o, downstream_vc_o}, 32'h0);
    step();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk($sformatf("post-rst credit%0d", i), 32'(credit_valid_o), 32'h0);
      chk($sformatf("post-rst flit_valid%0d", i), 32'(flit_valid_o), 32'h0);
    end
    chk("post-rst err", 32'(err_o), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
